// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and size helpers for the block-transfer memory controller.
// Imported by the arbiter and the controller top level.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} mem_burst_state_t;

    function automatic int calc_wb(input int word_width);
        return word_width / 8;
    endfunction

    function automatic int calc_beats(input int block_bytes, input int word_width);
        return block_bytes / (word_width / 8);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Bit offset of beat k inside a block-wide data vector.
    function automatic int slice_lsb(input int beat, input int word_width);
        return beat * word_width;
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Produces no grant when en is low.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int N = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt
);

    logic found;

    // Outer loop walks offsets from ptr; inner loop keeps every index a loop constant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (en && !found && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Multi-requester block-transfer controller: moves one cache block per request
// between NUM_REQ cache ports and a word-addressed synchronous RAM, one word per cycle.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int RAM_ADDR_W  = 10,
    parameter int RAM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_cs,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*BLOCK_BYTES*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              res_ack,
    output logic [BLOCK_BYTES*8-1:0]        res_rdata,
    output logic [NUM_REQ-1:0]              res_grant,
    output logic                            busy,
    output logic [RAM_ADDR_W-1:0]           ram_addr,
    output logic [WORD_WIDTH-1:0]           ram_wdata,
    output logic                            ram_wren,
    input  logic [WORD_WIDTH-1:0]           ram_q
);

    localparam int WB      = calc_wb(WORD_WIDTH);
    localparam int BEATS   = calc_beats(BLOCK_BYTES, WORD_WIDTH);
    localparam int BLOCK_W = BLOCK_BYTES * 8;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W   = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WB_SH   = (WB > 1) ? $clog2(WB) : 0;

    if ((WORD_WIDTH % 8 != 0) || (BLOCK_BYTES % WB != 0) || !is_pow2(BEATS) || (RAM_LATENCY < 1))
    begin : g_bad_cfg
        $error("mem_burst_ctrl: illegal WORD_WIDTH/BLOCK_BYTES/RAM_LATENCY combination");
    end

    mem_burst_state_t state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  rw_q, rw_d;
    logic [RAM_ADDR_W-1:0] base_q, base_d;
    logic [BLOCK_W-1:0]    wdata_q, wdata_d;
    logic [BLOCK_W-1:0]    rdata_q, rdata_d;
    logic [RAM_LATENCY-1:0]             cap_vld_q, cap_vld_d;
    logic [RAM_LATENCY-1:0][BEAT_W-1:0] cap_idx_q, cap_idx_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]      sel_owner;
    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BLOCK_W-1:0]    sel_wdata;
    logic [RAM_ADDR_W-1:0] sel_base;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_cs),
        .ptr (ptr_q),
        .en  (state_q == IDLE),
        .gnt (arb_gnt)
    );

    always_comb begin
        sel_owner = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_owner = PTR_W'(i);
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*BLOCK_W +: BLOCK_W];
            end
        end
        // Block-aligned base word, so base+k never carries out of the block.
        sel_base = RAM_ADDR_W'(sel_addr >> WB_SH) & ~RAM_ADDR_W'(BEATS - 1);
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        rw_d    = rw_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d = XFER;
                    grant_d = arb_gnt;
                    owner_d = sel_owner;
                    rw_d    = sel_rw;
                    base_d  = sel_base;
                    wdata_d = sel_wdata;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = rw_q ? DONE : DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: begin
                if (lat_q == LAT_W'(RAM_LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read beats travel down a latency-matched pipe and land in rdata when ram_q is valid.
    always_comb begin
        cap_vld_d    = '0;
        cap_idx_d    = '0;
        cap_vld_d[0] = (state_q == XFER) && !rw_q;
        cap_idx_d[0] = beat_q;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            cap_vld_d[i] = cap_vld_q[i-1];
            cap_idx_d[i] = cap_idx_q[i-1];
        end
        rdata_d = rdata_q;
        for (int k = 0; k < BEATS; k++) begin
            if (cap_vld_q[RAM_LATENCY-1] && (cap_idx_q[RAM_LATENCY-1] == BEAT_W'(k))) begin
                rdata_d[k*WORD_WIDTH +: WORD_WIDTH] = ram_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            rw_q      <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cap_vld_q <= '0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            rw_q      <= rw_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        res_grant = grant_q;
        res_ack   = (state_q == DONE) ? grant_q : '0;
        res_rdata = rdata_q;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        if (state_q == XFER) begin
            ram_addr = base_q + RAM_ADDR_W'(beat_q);
            ram_wren = rw_q;
            for (int k = 0; k < BEATS; k++) begin
                if (rw_q && (beat_q == BEAT_W'(k))) begin
                    ram_wdata = wdata_q[slice_lsb(k, WORD_WIDTH) +: WORD_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: a default instance (1-cycle RAM) and a
// 64-bit/32-byte instance behind a 3-cycle RAM.
module tb_mem_burst_ctrl;

    localparam logic [127:0] W0 = 128'h33323130_2f2e2d2c_2b2a2928_27262524;
    localparam logic [127:0] W1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] W2 = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    localparam logic [255:0] B0 = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // default instance
    logic [1:0]   a_cs = '0, a_rw = '0;
    logic [63:0]  a_addr = '0;
    logic [255:0] a_wdata = '0;
    logic [1:0]   a_ack, a_grant;
    logic [127:0] a_rdata;
    logic         a_busy, a_ram_wren;
    logic [9:0]   a_ram_addr;
    logic [31:0]  a_ram_wdata, a_ram_q;
    logic [31:0]  a_mem [1024];

    mem_burst_ctrl u_dut_a (
        .clk(clk), .rst(rst), .req_cs(a_cs), .req_rw(a_rw), .req_addr(a_addr),
        .req_wdata(a_wdata), .res_ack(a_ack), .res_rdata(a_rdata), .res_grant(a_grant),
        .busy(a_busy), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_wren(a_ram_wren),
        .ram_q(a_ram_q)
    );

    always @(posedge clk) begin
        if (a_ram_wren) a_mem[a_ram_addr] <= a_ram_wdata;
        a_ram_q <= a_mem[a_ram_addr];
    end

    // wide-word instance, 3-cycle RAM
    logic [1:0]   b_cs = '0, b_rw = '0;
    logic [63:0]  b_addr = '0;
    logic [511:0] b_wdata = '0;
    logic [1:0]   b_ack, b_grant;
    logic [255:0] b_rdata;
    logic         b_busy, b_ram_wren;
    logic [9:0]   b_ram_addr;
    logic [63:0]  b_ram_wdata, b_ram_q, b_p1, b_p2;
    logic [63:0]  b_mem [1024];

    mem_burst_ctrl #(.WORD_WIDTH(64), .BLOCK_BYTES(32), .RAM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_cs(b_cs), .req_rw(b_rw), .req_addr(b_addr),
        .req_wdata(b_wdata), .res_ack(b_ack), .res_rdata(b_rdata), .res_grant(b_grant),
        .busy(b_busy), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_wren(b_ram_wren),
        .ram_q(b_ram_q)
    );

    always @(posedge clk) begin
        if (b_ram_wren) b_mem[b_ram_addr] <= b_ram_wdata;
        b_p1    <= b_mem[b_ram_addr];
        b_p2    <= b_p1;
        b_ram_q <= b_p2;
    end

    typedef struct {
        int           ch;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           exp_lat;
        logic [9:0]   exp_base;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    logic [9:0] exp_q[$];
    logic [1:0] gnt_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic a_xfer(input vec_t v);
        bit got_ack = 0;
        @(negedge clk);
        a_cs[v.ch] = 1'b1;
        a_rw[v.ch] = v.rw;
        a_addr[v.ch*32 +: 32]   = v.addr;
        a_wdata[v.ch*128 +: 128] = v.wdata;
        for (int k = 0; k < 4; k++) exp_q.push_back(v.exp_base + 10'(k));
        for (int c = 1; c <= 40 && !got_ack; c++) begin
            @(negedge clk);
            if (c == 1) check("grant", a_grant, (v.ch == 1) ? 2'b10 : 2'b01);
            if (c <= 4) begin
                check("ram_addr", a_ram_addr, exp_q.pop_front());
                check("ram_wren", a_ram_wren, v.rw);
                if (v.rw) check("ram_wdata", a_ram_wdata, v.wdata[(c-1)*32 +: 32]);
            end
            if (a_ack != 2'b00) begin
                got_ack = 1;
                check("ack_onehot", a_ack, (v.ch == 1) ? 2'b10 : 2'b01);
                check("ack_latency", c, v.exp_lat);
                check("rdata", a_rdata, v.exp_rdata);
                check("ram_quiet_at_ack", {a_ram_wren, a_ram_addr}, 0);
                a_cs[v.ch] = 1'b0;
            end
        end
        if (!got_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: no ack for ch%0d addr %0h", v.ch, v.addr);
            a_cs = '0;
            exp_q.delete();
        end
        @(negedge clk);
        check("idle_after_ack", {a_busy, a_ack, a_grant}, 0);
    endtask

    task automatic b_xfer(input int ch, input logic rw, input logic [31:0] addr,
                          input logic [255:0] wdata, input int exp_lat,
                          input logic [9:0] exp_base, input logic [255:0] exp_rdata);
        bit got_ack = 0;
        @(negedge clk);
        b_cs[ch] = 1'b1;
        b_rw[ch] = rw;
        b_addr[ch*32 +: 32]    = addr;
        b_wdata[ch*256 +: 256] = wdata;
        for (int c = 1; c <= 40 && !got_ack; c++) begin
            @(negedge clk);
            if (c == 1) check("b_base", b_ram_addr, exp_base);
            if (c == 4) check("b_last_addr", b_ram_addr, exp_base + 10'd3);
            if (b_ack != 2'b00) begin
                got_ack = 1;
                check("b_ack_latency", c, exp_lat);
                check("b_rdata", b_rdata, exp_rdata);
                b_cs[ch] = 1'b0;
            end
        end
        if (!got_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_ack_timeout: no ack for ch%0d", ch);
            b_cs = '0;
        end
        @(negedge clk);
    endtask

    task automatic run_contention(input int n_acks, input bit hold);
        int seen = 0;
        for (int c = 0; c < 100 && seen < n_acks; c++) begin
            @(negedge clk);
            if (a_ack != 2'b00) begin
                seen++;
                check("rr_order", a_ack, gnt_q.pop_front());
                if (!hold || seen == n_acks) a_cs = a_cs & ~a_ack;
            end
        end
        if (seen < n_acks) begin
            n_tests++;
            n_fail++;
            $display("FAIL contention_timeout: %0d of %0d acks", seen, n_acks);
            a_cs = '0;
            gnt_q.delete();
        end
        @(negedge clk);
        a_cs = '0;
    endtask

    initial begin
        bit any_ack;
        vecs[0] = '{0, 1'b1, 32'h0000_0040, W0, 5, 10'h010, 128'h0};
        vecs[1] = '{1, 1'b0, 32'h0000_0040, '0, 6, 10'h010, W0};
        vecs[2] = '{1, 1'b1, 32'h0000_0ff0, W1, 5, 10'h3fc, W0};
        vecs[3] = '{0, 1'b0, 32'h0000_004f, '0, 6, 10'h010, W0};
        vecs[4] = '{0, 1'b0, 32'h0000_0ffc, '0, 6, 10'h3fc, W1};
        vecs[5] = '{1, 1'b1, 32'h0000_1234, W2, 5, 10'h08c, W1};
        vecs[6] = '{0, 1'b0, 32'h0000_0230, '0, 6, 10'h08c, W2};
        vecs[7] = '{0, 1'b0, 32'h0000_0040, '0, 6, 10'h010, W0};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {a_ack, a_rdata, a_grant, a_busy, a_ram_addr, a_ram_wdata, a_ram_wren}, 0);
        rst = 1'b0;

        // reset in the middle of a write burst
        @(negedge clk);
        a_cs[0] = 1'b1; a_rw[0] = 1'b1; a_addr[31:0] = 32'h80; a_wdata[127:0] = W1;
        repeat (2) @(negedge clk);
        check("mid_xfer_addr", {a_ram_wren, a_ram_addr}, {1'b1, 10'h021});
        rst = 1'b1;
        #1;
        check("reset_mid_xfer", {a_ack, a_rdata, a_grant, a_busy, a_ram_addr, a_ram_wdata, a_ram_wren}, 0);
        a_cs = '0;
        @(negedge clk);
        rst = 1'b0;
        any_ack = 0;
        repeat (8) begin
            @(negedge clk);
            any_ack |= (a_ack != 2'b00);
        end
        check("no_ack_after_reset", any_ack, 0);

        for (int i = 0; i < 8; i++) a_xfer(vecs[i]);

        // contention from reset: ch0 first, then ch1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        a_rw = 2'b00; a_addr = {32'h40, 32'h40};
        a_cs = 2'b11;
        gnt_q = '{2'b01, 2'b10};
        run_contention(2, 1'b0);

        // both held: grants alternate
        a_cs = 2'b11;
        gnt_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        run_contention(4, 1'b1);

        // wide words behind a 3-cycle RAM
        b_xfer(0, 1'b1, 32'h100, B0, 5, 10'h020, 256'h0);
        b_xfer(1, 1'b0, 32'h100, '0, 8, 10'h020, B0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
